// File: rtl/ccff_loader_pkg.sv
// ============================================================================
// Module      : ccff_loader_pkg
// Description : Shared state encoding and sizing helper for the chain loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ccff_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_SHIFT  = 3'd2,
      ST_RB_OUT = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // Number of bitstream words needed to cover a chain of chain_len flops.
   function automatic int nwords(input int chain_len, input int word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ccff_word_serializer.sv
// ============================================================================
// Module      : ccff_word_serializer
// Description : Word shift register, in-word bit counter and readback capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccff_word_serializer #(
   parameter int WORD_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [WORD_W-1:0] i_word,
   input  logic              i_shift,
   input  logic              i_capture,
   input  logic              i_tail,
   output logic              o_head,
   output logic              o_word_last,
   output logic [WORD_W-1:0] o_rb_data
);

   localparam int WBW = $clog2(WORD_W + 1);
   localparam logic [WBW-1:0] C_LAST_WBIT = WBW'(WORD_W - 1);

   logic [WORD_W-1:0] r_shreg;
   logic [WBW-1:0]    r_word_bit;
   logic [WORD_W-1:0] r_rb;
   logic [WORD_W-1:0] w_rb_next;

   // The tail bit lands at the current in-word position; bits never reached stay zero.
   always_comb begin
      w_rb_next = r_rb;
      for (int i = 0; i < WORD_W; i++) begin
         if (i_capture && (r_word_bit == WBW'(i))) begin
            w_rb_next[i] = i_tail;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shreg    <= '0;
         r_word_bit <= '0;
         r_rb       <= '0;
      end else if (i_load) begin
         r_shreg    <= i_word;
         r_word_bit <= '0;
         r_rb       <= '0;
      end else if (i_shift) begin
         r_shreg    <= r_shreg >> 1;
         r_word_bit <= r_word_bit + 1'b1;
         r_rb       <= w_rb_next;
      end
   end

   assign o_head      = r_shreg[0];
   assign o_word_last = (r_word_bit == C_LAST_WBIT);
   assign o_rb_data   = r_rb;

endmodule

`default_nettype wire

// File: rtl/ccff_chain_loader.sv
// ============================================================================
// Module      : ccff_chain_loader
// Description : Serializes bitstream words into a configuration chain, with
//               optional readback of the previous chain contents.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter int CHAIN_LEN = 31,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              prog_rst_n,
   input  logic              start,
   input  logic              readback,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid,
   input  logic              rb_ready,
   output logic              ccff_head,
   output logic              chain_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done
);

   localparam int BCW = $clog2(CHAIN_LEN + 1);
   localparam logic [BCW-1:0] C_LAST_BIT  = BCW'(CHAIN_LEN - 1);
   localparam logic [BCW-1:0] C_CHAIN_END = BCW'(CHAIN_LEN);

   state_t         r_state;
   state_t         w_next;
   logic [BCW-1:0] r_bit_cnt;
   logic           r_rb_mode;
   logic           r_cfg_ready;
   logic           r_rb_valid;
   logic           r_busy;
   logic           r_done;

   logic w_load;
   logic w_shift;
   logic w_chain_last;
   logic w_word_last;
   logic w_ser_head;

   assign w_load       = (r_state == ST_FETCH) && cfg_valid;
   assign w_shift      = (r_state == ST_SHIFT);
   assign w_chain_last = (r_bit_cnt == C_LAST_BIT);

   ccff_word_serializer #(
      .WORD_W (WORD_W)
   ) u_ser (
      .clk         (prog_clk),
      .rst_n       (prog_rst_n),
      .i_load      (w_load),
      .i_word      (cfg_data),
      .i_shift     (w_shift),
      .i_capture   (w_shift && r_rb_mode),
      .i_tail      (ccff_tail),
      .o_head      (w_ser_head),
      .o_word_last (w_word_last),
      .o_rb_data   (rb_data)
   );

   // Exit tests look at the pre-increment counts so neither counter overruns.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_next = ST_FETCH;
         ST_FETCH:  if (cfg_valid) w_next = ST_SHIFT;
         ST_SHIFT: begin
            if (w_chain_last || w_word_last) begin
               if (r_rb_mode)         w_next = ST_RB_OUT;
               else if (w_chain_last) w_next = ST_DONE;
               else                   w_next = ST_FETCH;
            end
         end
         ST_RB_OUT: begin
            if (rb_ready) w_next = (r_bit_cnt == C_CHAIN_END) ? ST_DONE : ST_FETCH;
         end
         ST_DONE:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= '0;
         r_rb_mode   <= 1'b0;
         r_cfg_ready <= 1'b0;
         r_rb_valid  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_cfg_ready <= (w_next == ST_FETCH);
         r_rb_valid  <= (w_next == ST_RB_OUT);
         r_busy      <= (w_next != ST_IDLE);
         r_done      <= (w_next == ST_DONE);
         if ((r_state == ST_IDLE) && start) begin
            r_rb_mode <= readback;
            r_bit_cnt <= '0;
         end else if (w_shift) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
      end
   end

   assign cfg_ready      = r_cfg_ready;
   assign rb_valid       = r_rb_valid;
   assign busy           = r_busy;
   assign done           = r_done;
   assign chain_shift_en = w_shift;
   assign ccff_head      = w_shift && w_ser_head;

endmodule

`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
// ============================================================================
// Module      : tb_ccff_chain_loader
// Description : Directed bench for ccff_chain_loader with a 31-flop chain model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ccff_chain_loader;

   localparam int CL = 31;
   localparam int WW = 8;

   logic          prog_clk = 1'b0;
   logic          prog_rst_n = 1'b0;
   logic          start = 1'b0;
   logic          readback = 1'b0;
   logic [WW-1:0] cfg_data = '0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [WW-1:0] rb_data;
   logic          rb_valid;
   logic          rb_ready = 1'b0;
   logic          ccff_head;
   logic          chain_shift_en;
   logic          ccff_tail;
   logic          busy;
   logic          done;

   ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
      .prog_clk       (prog_clk),
      .prog_rst_n     (prog_rst_n),
      .start          (start),
      .readback       (readback),
      .cfg_data       (cfg_data),
      .cfg_valid      (cfg_valid),
      .cfg_ready      (cfg_ready),
      .rb_data        (rb_data),
      .rb_valid       (rb_valid),
      .rb_ready       (rb_ready),
      .ccff_head      (ccff_head),
      .chain_shift_en (chain_shift_en),
      .ccff_tail      (ccff_tail),
      .busy           (busy),
      .done           (done)
   );

   always #5 prog_clk = ~prog_clk;

   // Chain model: index 0 is the flop driving ccff_tail.
   logic [CL-1:0] chain = '0;
   logic [CL-1:0] pre_val = '0;
   logic          pre_req = 1'b0;
   always @(posedge prog_clk) begin
      if (pre_req)             chain <= pre_val;
      else if (chain_shift_en) chain <= {ccff_head, chain[CL-1:1]};
   end
   assign ccff_tail = chain[0];

   // Monitor: counts events and protocol violations, sampled mid-cycle.
   logic       clr = 1'b0;
   int         cnt_shift = 0, cnt_done = 0, cnt_busy = 0, cnt_words = 0, cnt_rb = 0, proto_err = 0;
   logic [7:0] rb_cap [4];
   logic       p_hs = 1'b0, p_st = 1'b0, p_rbv = 1'b0, p_rbr = 1'b0, p_done = 1'b0;
   logic [7:0] p_rbd = '0;
   always @(negedge prog_clk) begin
      if (clr) begin
         cnt_shift <= 0; cnt_done <= 0; cnt_busy <= 0; cnt_words <= 0; cnt_rb <= 0; proto_err <= 0;
         p_hs <= 1'b0; p_st <= 1'b0; p_rbv <= 1'b0; p_rbr <= 1'b0; p_done <= 1'b0;
         for (int i = 0; i < 4; i++) rb_cap[i] <= '0;
      end else begin
         cnt_shift <= cnt_shift + int'(chain_shift_en);
         cnt_done  <= cnt_done + int'(done);
         cnt_busy  <= cnt_busy + int'(busy);
         cnt_words <= cnt_words + int'(cfg_valid && cfg_ready);
         proto_err <= proto_err + int'((p_hs && !chain_shift_en) ||
                                       (p_st && !(busy && cfg_ready)) ||
                                       (p_rbv && !p_rbr && rb_valid && (rb_data !== p_rbd)) ||
                                       (rb_valid && chain_shift_en) ||
                                       (done && !busy) ||
                                       (p_done && (busy || done)));
         if (rb_valid && rb_ready) begin
            if (cnt_rb < 4) rb_cap[cnt_rb] <= rb_data;
            cnt_rb <= cnt_rb + 1;
         end
         p_hs <= cfg_valid && cfg_ready;
         p_st <= start && !busy;
         p_rbv <= rb_valid; p_rbr <= rb_ready; p_rbd <= rb_data; p_done <= done;
      end
   end

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic feed_word(input logic [7:0] b, input int gap);
      int n = 0;
      while (!cfg_ready && n < 40) begin tick(); n++; end
      chk("cfg_ready_timeout", 64'(n < 40), 64'd1);
      repeat (gap) tick();
      cfg_data = b; cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
   endtask

   typedef struct {
      logic [31:0]   data;
      logic          rb;
      int            gap;
      int            stall;
      logic          mid;
      logic [CL-1:0] pre;
      logic [CL-1:0] exp_chain;
      logic [31:0]   exp_rb;
      int            exp_busy;
   } vec_t;

   task automatic run_pass(input vec_t v, input string tag);
      int n;
      clr = 1'b1; @(negedge prog_clk); #1 clr = 1'b0;
      tick();
      pre_val = v.pre; pre_req = 1'b1;
      tick();
      pre_req = 1'b0; start = 1'b1; readback = v.rb;
      tick();
      start = 1'b0; readback = 1'b0;
      for (int w = 0; w < 4; w++) begin
         feed_word(v.data[8*w +: 8], (w > 0) ? v.gap : 0);
         if (v.mid && w == 1) begin
            start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hFF;
            repeat (2) tick();
            start = 1'b0; cfg_valid = 1'b0;
         end
         if (v.rb) begin
            n = 0;
            while (!rb_valid && n < 40) begin tick(); n++; end
            chk({tag, "_rb_valid_timeout"}, 64'(n < 40), 64'd1);
            if (w == 1) repeat (v.stall) tick();
            rb_ready = 1'b1;
            tick();
            rb_ready = 1'b0;
         end
      end
      n = 0;
      while (!done && n < 200) begin tick(); n++; end
      chk({tag, "_done_timeout"}, 64'(n < 200), 64'd1);
      repeat (3) tick();
      chk({tag, "_chain"},  64'(chain),     64'(v.exp_chain));
      chk({tag, "_shifts"}, 64'(cnt_shift), 64'(CL));
      chk({tag, "_dones"},  64'(cnt_done),  64'd1);
      chk({tag, "_words"},  64'(cnt_words), 64'd4);
      chk({tag, "_busy_cycles"}, 64'(cnt_busy), 64'(v.exp_busy));
      chk({tag, "_protocol"}, 64'(proto_err), 64'd0);
      if (v.rb) chk({tag, "_rb_data"}, 64'({rb_cap[3], rb_cap[2], rb_cap[1], rb_cap[0]}), 64'(v.exp_rb));
   endtask

   vec_t vecs [5];

   initial begin
      //         data          rb    gap stall mid   preload       chain         readback      busy
      vecs[0] = '{32'hF10FC35A, 1'b0, 0, 0, 1'b0, 31'h00000000, 31'h710FC35A, 32'h0,        36};
      vecs[1] = '{32'h0BADF00D, 1'b1, 0, 0, 1'b0, 31'h12345678, 31'h0BADF00D, 32'h12345678, 40};
      vecs[2] = '{32'hDEADBEEF, 1'b1, 0, 5, 1'b0, 31'h7FFFFFFF, 31'h5EADBEEF, 32'h7FFFFFFF, 45};
      vecs[3] = '{32'hF10FC35A, 1'b0, 3, 0, 1'b0, 31'h2AAAAAAA, 31'h710FC35A, 32'h0,        45};
      vecs[4] = '{32'h13579BDF, 1'b0, 0, 0, 1'b1, 31'h00000000, 31'h13579BDF, 32'h0,        36};

      repeat (3) tick();
      chk("reset_outputs",
          64'({cfg_ready, rb_valid, chain_shift_en, ccff_head, busy, done, rb_data}), 64'd0);
      prog_rst_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) run_pass(vecs[i], $sformatf("vec%0d", i));

      // Reset asserted during the shift of chain bit 12.
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      feed_word(8'h5A, 0);
      feed_word(8'hC3, 0);
      repeat (4) tick();
      chk("pre_reset_shift_en", 64'(chain_shift_en), 64'd1);
      #2 prog_rst_n = 1'b0;
      #1 chk("mid_reset_outputs",
             64'({cfg_ready, rb_valid, chain_shift_en, ccff_head, busy, done, rb_data}), 64'd0);
      repeat (2) tick();
      prog_rst_n = 1'b1;
      tick();
      run_pass('{32'hF10FC35A, 1'b0, 0, 0, 1'b0, 31'h55555555, 31'h710FC35A, 32'h0, 36}, "restart");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
